// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receiver bundle: raw keyboard lines in, decoded key events out.
// master = keyboard / host-side driver, slave = receiver.
interface ps2_keyboard_rx_if;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output PS2_CLK, PS2_DATA,
        input  key_code, key_break, key_ext, key_valid, frame_err, busy
    );

    modport slave (
        input  PS2_CLK, PS2_DATA,
        output key_code, key_break, key_ext, key_valid, frame_err, busy
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix decoding and inter-edge timeout.
// Result pulses one cycle after the stop-bit edge; no backpressure (events are fire-and-forget pulses).
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_keyboard_rx_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q;
    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TW-1:0]   to_cnt_q;
    logic            ext_pend_q, brk_pend_q;
    logic [7:0]      key_code_q;
    logic            key_break_q, key_ext_q, key_valid_q, frame_err_q;

    logic fall_d, byte_good_d, timeout_d;

    assign fall_d      = clk_prev_q & ~clk_s2_q;
    // Odd parity over data+parity, and stop bit (sampled now) must be 1.
    assign byte_good_d = (^{shift_q, par_q}) & dat_s2_q;
    assign timeout_d   = (to_cnt_q == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= bus.PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus.PS2_DATA;
            dat_s2_q   <= dat_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_code_q  <= 8'h00;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == IDLE || fall_d) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            // A falling edge in the timeout cycle still counts as progress.
            if (state_q != IDLE && timeout_d && !fall_d) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                ext_pend_q  <= 1'b0;
                brk_pend_q  <= 1'b0;
                to_cnt_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fall_d && !dat_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        if (fall_d) begin
                            shift_q   <= {dat_s2_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (fall_d) begin
                            par_q   <= dat_s2_q;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (fall_d) begin
                            state_q <= IDLE;
                            if (!byte_good_d) begin
                                frame_err_q <= 1'b1;
                                ext_pend_q  <= 1'b0;
                                brk_pend_q  <= 1'b0;
                            end else if (shift_q == 8'hE0) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_pend_q <= 1'b1;
                            end else begin
                                key_code_q  <= shift_q;
                                key_ext_q   <= ext_pend_q;
                                key_break_q <= brk_pend_q;
                                key_valid_q <= 1'b1;
                                ext_pend_q  <= 1'b0;
                                brk_pend_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_break = key_break_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
